// File: rtl/adder_seq32.sv
`default_nettype none
// ============================================================================
//  Module      : adder_seq32
//  Description : Multi-cycle adder/subtractor. Each RUN cycle adds one
//                SLICE-bit chunk of the latched operands with a lookahead
//                slice, LSB slice first. Results appear on sum/cout/ovf only
//                at completion and hold until the next completion.
//  Ports       : clk    - clock, rising edge
//                rst    - asynchronous active-high reset
//                start  - request an operation (accepted in IDLE or DONE)
//                sub    - 0: a+b+cin, 1: a-b (cin ignored)
//                a, b   - WIDTH-bit operands, free to change after acceptance
//                cin    - carry-in for add mode
//                busy   - high while in RUN
//                done   - one-cycle completion pulse
//                sum    - WIDTH-bit result
//                cout   - carry out of MSB (1 = no borrow when subtracting)
//                ovf    - two's-complement overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_seq32 #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int C_NSLICE = WIDTH / SLICE;
    localparam int C_IDX_W  = (C_NSLICE > 1) ? $clog2(C_NSLICE) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_NSLICE - 1);

    localparam logic [1:0] C_S_IDLE = 2'd0;
    localparam logic [1:0] C_S_RUN  = 2'd1;
    localparam logic [1:0] C_S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_bx;      // b, already inverted for subtraction
    logic               r_carry;
    logic [C_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_work;

    logic               w_accept;
    logic               w_last;
    int                 w_base;
    logic [SLICE-1:0]   w_a_sl;
    logic [SLICE-1:0]   w_b_sl;
    logic [SLICE-1:0]   w_g;
    logic [SLICE-1:0]   w_p;
    logic [SLICE:0]     w_c;
    logic [SLICE-1:0]   w_slice_sum;
    logic [WIDTH-1:0]   w_work_next;

    assign w_accept = start && ((r_state == C_S_IDLE) || (r_state == C_S_DONE));
    assign w_last   = (r_state == C_S_RUN) && (r_idx == C_LAST_IDX);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; start during RUN is deliberately ignored
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_S_IDLE: if (start) w_state_next = C_S_RUN;
            C_S_RUN:  if (w_last) w_state_next = C_S_DONE;
            C_S_DONE: w_state_next = start ? C_S_RUN : C_S_IDLE;
            default:  w_state_next = C_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state == C_S_RUN);
        done = (r_state == C_S_DONE);
    end

    // ------------------------------------------------------------------
    // Slice adder: generate/propagate lookahead over the current slice
    // ------------------------------------------------------------------
    always_comb begin : p_slice
        logic [SLICE:0] v_c;
        w_base = int'(r_idx) * SLICE;
        w_a_sl = r_a[w_base +: SLICE];
        w_b_sl = r_bx[w_base +: SLICE];
        w_g    = w_a_sl & w_b_sl;
        w_p    = w_a_sl ^ w_b_sl;
        v_c    = '0;
        v_c[0] = r_carry;
        for (int i = 0; i < SLICE; i++) begin
            v_c[i+1] = w_g[i] | (w_p[i] & v_c[i]);
        end
        w_c         = v_c;
        w_slice_sum = w_p ^ v_c[SLICE-1:0];
    end

    // Working value with the current slice merged in; on the last slice this
    // is the complete result, which lets sum/ovf load in the same edge.
    always_comb begin
        w_work_next = r_work;
        w_work_next[w_base +: SLICE] = w_slice_sum;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_bx    <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_work  <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_bx    <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
        end else if (r_state == C_S_RUN) begin
            r_work  <= w_work_next;
            r_carry <= w_c[SLICE];
            if (w_last) begin
                r_idx <= '0;
                sum   <= w_work_next;
                cout  <= w_c[SLICE];
                ovf   <= (r_a[WIDTH-1] == r_bx[WIDTH-1]) &&
                         (w_work_next[WIDTH-1] != r_a[WIDTH-1]);
            end else begin
                r_idx <= r_idx + C_IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
